// File: rtl/pipe_skid_reg.sv
// Elastic pipeline stage: valid/ready on both sides, two-entry skid buffer, falling-edge state.
// Optional macro PIPE_SKID_FLUSH_EN adds a Flush input that empties the stage.
module pipe_skid_reg #(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Clr,
   input  logic             In_Valid,
   output logic             In_Ready,
   input  logic [WIDTH-1:0] In_Data,
   output logic             Out_Valid,
   input  logic             Out_Ready,
   output logic [WIDTH-1:0] Out_Data,
`ifdef PIPE_SKID_FLUSH_EN
   input  logic             Flush,
`endif
   output logic [1:0]       Count
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             accept, consume;

   // In_Ready comes only from registered state and Clr, never from Out_Ready.
   assign In_Ready  = (state_q != ST_FULL) & ~Clr;
   assign Out_Valid = (state_q != ST_EMPTY);
   assign Out_Data  = main_q;
   assign Count     = 2'(state_q);

   assign accept  = In_Valid & In_Ready;
   assign consume = Out_Valid & Out_Ready;

   always_comb begin
      // NOTE: every signal gets a hold default first so no path leaves one unassigned (no latch).
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               main_d  = In_Data;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
            if (accept && consume) begin
               main_d = In_Data;
            end else if (accept) begin
               skid_d  = In_Data;
               state_d = ST_FULL;
            end else if (consume) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (consume) begin
               main_d  = skid_q;
               state_d = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
`ifdef PIPE_SKID_FLUSH_EN
      // Flush wins over any handshake; stored payloads stay but are no longer valid.
      if (Flush) begin
         state_d = ST_EMPTY;
         main_d  = main_q;
         skid_d  = skid_q;
      end
`endif
   end

   always_ff @(negedge Clk or posedge Clr) begin
      if (Clr) begin
         state_q <= ST_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values of the others.
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: vector table plus FIFO scoreboard of expected payloads.
// Define PIPE_SKID_FLUSH_EN for both files to exercise the Flush sequences.
module tb_pipe_skid_reg;

   logic        Clk = 1'b0;
   logic        Clr;
   logic        In_Valid;
   logic        In_Ready;
   logic [31:0] In_Data;
   logic        Out_Valid;
   logic        Out_Ready;
   logic [31:0] Out_Data;
   logic [1:0]  Count;
   logic        flush;

   pipe_skid_reg #(.WIDTH(32)) dut (
      .Clk       (Clk),
      .Clr       (Clr),
      .In_Valid  (In_Valid),
      .In_Ready  (In_Ready),
      .In_Data   (In_Data),
      .Out_Valid (Out_Valid),
      .Out_Ready (Out_Ready),
      .Out_Data  (Out_Data),
`ifdef PIPE_SKID_FLUSH_EN
      .Flush     (flush),
`endif
      .Count     (Count)
   );

   always #5 Clk = ~Clk;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_data = '0;

   typedef struct {
      logic        iv;
      logic [31:0] data;
      logic        ordy;
      int          exp_count;
      logic        exp_ready;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected Out_Data: head of the queue, or the last payload held in main when empty.
   task automatic check_outputs(input string tag);
      check({tag, " out_valid"}, 32'(Out_Valid), 32'(exp_q.size() != 0));
      check({tag, " count"}, 32'(Count), 32'(exp_q.size()));
      check({tag, " out_data"}, Out_Data, (exp_q.size() != 0) ? exp_q[0] : last_data);
   endtask

   // Inputs change 1ns after a falling edge, outputs are sampled there too.
   task automatic step(input logic iv, input logic [31:0] d, input logic ordy, input logic fl,
                       input string tag);
      logic rdy, acc, con;
      In_Valid  = iv;
      In_Data   = d;
      Out_Ready = ordy;
      flush     = fl;
      #1;
      rdy = (exp_q.size() < 2) && !Clr;
      check({tag, " in_ready"}, 32'(In_Ready), 32'(rdy));
      acc = iv && rdy;
      con = (exp_q.size() != 0) && ordy;
      @(negedge Clk);
      #1;
      if (fl) begin
         if (exp_q.size() != 0) last_data = exp_q[0];
         exp_q.delete();
      end else begin
         if (con) last_data = exp_q.pop_front();
         if (acc) exp_q.push_back(d);
      end
      check_outputs(tag);
   endtask

   initial begin
      vecs[0]  = '{1'b1, 32'h1, 1'b1, 1, 1'b1};
      vecs[1]  = '{1'b1, 32'h2, 1'b1, 1, 1'b1};
      vecs[2]  = '{1'b1, 32'h3, 1'b1, 1, 1'b1};
      vecs[3]  = '{1'b0, 32'h0, 1'b1, 0, 1'b1};
      vecs[4]  = '{1'b1, 32'hA, 1'b0, 1, 1'b1};
      vecs[5]  = '{1'b1, 32'hB, 1'b0, 2, 1'b0};
      vecs[6]  = '{1'b0, 32'h0, 1'b1, 1, 1'b1};
      vecs[7]  = '{1'b0, 32'h0, 1'b1, 0, 1'b1};
      vecs[8]  = '{1'b1, 32'h5, 1'b0, 1, 1'b1};
      vecs[9]  = '{1'b1, 32'h6, 1'b1, 1, 1'b1};
      vecs[10] = '{1'b0, 32'h0, 1'b1, 0, 1'b1};

      Clr = 1'b1; In_Valid = 1'b0; In_Data = '0; Out_Ready = 1'b0; flush = 1'b0;
      @(negedge Clk);
      #1;
      check("reset in_ready", 32'(In_Ready), 32'd0);
      check_outputs("reset");
      @(posedge Clk);
      Clr = 1'b0;
      #1;
      check("release in_ready", 32'(In_Ready), 32'd1);
      @(negedge Clk);
      #1;

      // Streaming, backpressure, simultaneous accept/consume.
      for (int i = 0; i < 11; i++) begin
         step(vecs[i].iv, vecs[i].data, vecs[i].ordy, 1'b0, $sformatf("vec%0d", i));
         check($sformatf("vec%0d tbl_count", i), 32'(Count), 32'(vecs[i].exp_count));
         check($sformatf("vec%0d tbl_ready", i), 32'(In_Ready), 32'(vecs[i].exp_ready));
      end
      check("stale out_data", Out_Data, 32'h6);

      // Hold stability: FULL for 5 cycles while 0xC waits upstream.
      step(1'b1, 32'hA, 1'b0, 1'b0, "hold fill0");
      step(1'b1, 32'hB, 1'b0, 1'b0, "hold fill1");
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 32'hC, 1'b0, 1'b0, $sformatf("hold%0d", i));
         check($sformatf("hold%0d data", i), Out_Data, 32'hA);
      end
      step(1'b1, 32'hC, 1'b1, 1'b0, "unstall");
      check("unstall data", Out_Data, 32'hB);
      step(1'b1, 32'hC, 1'b1, 1'b0, "accept C");
      check("accept C data", Out_Data, 32'hC);
      step(1'b0, 32'h0, 1'b1, 1'b0, "drain C");

      // Random traffic through the scoreboard.
      for (int i = 0; i < 60; i++) begin
         step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0,
              $sformatf("rnd%0d", i));
      end
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0, "rnd drain");

`ifdef PIPE_SKID_FLUSH_EN
      step(1'b1, 32'h8, 1'b0, 1'b0, "fl fill0");
      step(1'b1, 32'h9, 1'b0, 1'b0, "fl fill1");
      step(1'b1, 32'h7, 1'b0, 1'b1, "flush full");
      check("flush full data", Out_Data, 32'h8);
      step(1'b1, 32'h4, 1'b1, 1'b0, "fl one");
      step(1'b1, 32'h7, 1'b1, 1'b1, "flush one");
      check("flush one data", Out_Data, 32'h4);
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0, "post flush");
`endif

      // Reset mid-stream with two payloads held.
      step(1'b1, 32'hD, 1'b0, 1'b0, "rst fill0");
      step(1'b1, 32'hE, 1'b0, 1'b0, "rst fill1");
      check("rst pre count", 32'(Count), 32'd2);
      #2;
      Clr = 1'b1;
      #1;
      exp_q.delete();
      last_data = '0;
      check("rst mid in_ready", 32'(In_Ready), 32'd0);
      check_outputs("rst mid");
      In_Valid = 1'b1; In_Data = 32'hF; Out_Ready = 1'b1;
      @(negedge Clk);
      #1;
      check("rst edge in_ready", 32'(In_Ready), 32'd0);
      check_outputs("rst edge");
      Clr = 1'b0;
      In_Valid = 1'b0;
      #1;
      check("rst release in_ready", 32'(In_Ready), 32'd1);
      step(1'b1, 32'h11, 1'b1, 1'b0, "post rst");
      step(1'b0, 32'h0, 1'b1, 1'b0, "post rst drain");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
